// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with three modes.
//   direct (00) : Out <= 1<<In one cycle after the input is sampled.
//   scan   (01) : free-running one-hot walk, each line held DWELL cycles.
//   pulse  (10) : one-shot DWELL-cycle strobe on line In, triggered by start.
//   idle   (11) : outputs off.
// A change of `mode` costs one flush cycle that clears all state.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   E           enable (0 turns outputs off)
//   mode [1:0]  operating mode
//   In   [N-1:0] line select (direct, pulse)
//   start       pulse trigger, level-sampled
//   Out  [2^N-1:0] registered one-hot outputs or zero
//   idx  [N-1:0] current / last selected line
//   busy        pulse in progress
//   wrap        one-cycle flag when scan returns to line 0
module decoder_n_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               E,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       In,
    input  logic               start,
    output logic [(1<<N)-1:0]  Out,
    output logic [N-1:0]       idx,
    output logic               busy,
    output logic               wrap
);
    localparam int L  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [L-1:0]  ONE  = L'(1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_SCAN   = 2'b01,
        M_PULSE  = 2'b10,
        M_IDLE   = 2'b11
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [N-1:0]  idx_q,  idx_d;
    logic [L-1:0]  out_q,  out_d;
    logic          busy_q, busy_d;
    logic          wrap_q, wrap_d;
    logic [N-1:0]  idx_nx;

    assign idx_nx = idx_q + N'(1);   // wraps mod 2^N naturally

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        out_d  = out_q;
        busy_d = busy_q;
        wrap_d = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            // flush cycle: everything cleared, other inputs ignored
            mode_d = mode_e'(mode);
            cnt_d  = '0;
            idx_d  = '0;
            out_d  = '0;
            busy_d = 1'b0;
        end else begin
            unique case (mode_q)
                M_DIRECT: begin
                    busy_d = 1'b0;
                    if (E) begin
                        out_d = ONE << In;
                        idx_d = In;
                    end else begin
                        out_d = '0;
                    end
                end
                M_SCAN: begin
                    busy_d = 1'b0;
                    if (!E) begin
                        out_d = '0;          // idx/cnt hold for resume
                    end else if (out_q == '0) begin
                        // start or resume: re-assert idx with a full dwell
                        out_d = ONE << idx_q;
                        cnt_d = '0;
                    end else if (cnt_q == LAST) begin
                        idx_d  = idx_nx;
                        out_d  = ONE << idx_nx;
                        cnt_d  = '0;
                        wrap_d = &idx_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                M_PULSE: begin
                    if (!E) begin
                        out_d  = '0;
                        busy_d = 1'b0;
                        cnt_d  = '0;
                    end else if (busy_q) begin
                        // start/In ignored while busy, terminating edge included
                        if (cnt_q == LAST) begin
                            out_d  = '0;
                            busy_d = 1'b0;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (start) begin
                        out_d  = ONE << In;
                        idx_d  = In;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
                default: begin
                    out_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            wrap_q <= wrap_d;
        end
    end

    assign Out  = out_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule
